// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types for the UART transmit arbiter
package uart_pkg;

  // Arbiter states: IDLE picks an owner, LOCK streams that owner's packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - rotating-priority search starting just after last_grant
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            found,
  output logic [IW-1:0]   index
);

  // Requester index 'off' positions above base, wrapping at NREQ.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return IW'(sum % NREQ);
  endfunction

  // Walk offsets 1..NREQ; the nearest requester after last_grant wins, so
  // the previous owner is considered last.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!found && req[wrap_idx(last_grant, off)]) begin
        found = 1'b1;
        index = wrap_idx(last_grant, off);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding a UART TX FIFO
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8,
  parameter int MAXLEN = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DWIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [DWIDTH-1:0]         tx_data,
  output logic                      tx_wen,
  input  logic                      tx_full,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      trunc_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAXLEN - 1);

  arb_state_t      state;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   byte_cnt;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            owner_valid;
  logic            owner_last;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_idx)
  );

  assign owner_valid = req_valid[grant_id];
  assign owner_last  = req_last[grant_id];
  assign tx_data     = req_data[int'(grant_id) * DWIDTH +: DWIDTH];

  // A byte moves only while locked, the owner has data and the FIFO has room;
  // rst masks the strobe so an abandoned packet leaks nothing in the reset cycle.
  assign tx_wen = (state == LOCK) && owner_valid && !tx_full && !rst;

  assign busy = (state == LOCK);

  // Only the owner sees ready, and only when the FIFO can take a byte.
  always_comb begin
    req_ready = '0;
    if ((state == LOCK) && !tx_full && !rst) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Arbitration FSM: lock an owner, count its bytes, release on last or at MAXLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      byte_cnt   <= '0;
      trunc_err  <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            byte_cnt <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (tx_wen) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (owner_last) begin
              state      <= IDLE;
              last_grant <= grant_id;
            end else if (byte_cnt == LAST_CNT) begin
              // Forced release; the owner keeps its remaining bytes and
              // competes again from the next IDLE cycle.
              state      <= IDLE;
              last_grant <= grant_id;
              trunc_err  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 8;
  localparam int MAXLEN = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic [DWIDTH-1:0]      tx_data;
  logic                   tx_wen;
  logic                   tx_full;
  logic [1:0]             grant_id;
  logic                   busy;
  logic                   trunc_err;

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .DWIDTH (DWIDTH),
    .MAXLEN (MAXLEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_wen    (tx_wen),
    .tx_full   (tx_full),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  // Per-requester byte sources
  logic [7:0] qd [NREQ][16];
  bit         ql [NREQ][16];
  int         qh [NREQ];
  int         qt [NREQ];

  // Log of bytes written to the FIFO
  logic [7:0] log_d [64];
  int         log_g [64];
  int         log_c [64];
  int         nlog;
  int         cyc;
  int         trunc_n;
  int         trunc_c;
  int         busy_n;

  logic       o_wen;
  logic [3:0] o_ready;
  logic       o_busy;
  logic [1:0] o_gid;
  logic       o_trunc;

  int total;
  int bad;

  int t2_d [7] = '{'h10, 'h11, 'h20, 'h21, 'h12, 'h13, 'h22};
  int t2_g [7] = '{0, 0, 1, 1, 0, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit l);
    qd[r][qt[r]] = d;
    ql[r][qt[r]] = l;
    qt[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (qh[i] < qt[i]) begin
        req_valid[i]              = 1'b1;
        req_data[i*DWIDTH +: DWIDTH] = qd[i][qh[i]];
        req_last[i]               = ql[i][qh[i]];
      end else begin
        req_valid[i]              = 1'b0;
        req_data[i*DWIDTH +: DWIDTH] = '0;
        req_last[i]               = 1'b0;
      end
    end
  endtask

  task automatic flush_reqs();
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
    drive();
  endtask

  task automatic clear_log();
    nlog    = 0;
    trunc_n = 0;
    trunc_c = -1;
    busy_n  = 0;
  endtask

  // One clock: sample at negedge, then advance sources past accepted bytes.
  task automatic step();
    logic [3:0] fire;
    @(negedge clk);
    o_wen   = tx_wen;
    o_ready = req_ready;
    o_busy  = busy;
    o_gid   = grant_id;
    o_trunc = trunc_err;
    fire    = req_valid & req_ready;
    if (tx_full) check("wen_while_full", {31'd0, tx_wen}, 32'd0);
    if (tx_wen && nlog < 64) begin
      log_d[nlog] = tx_data;
      log_g[nlog] = int'(grant_id);
      log_c[nlog] = cyc;
      nlog++;
    end
    if (trunc_err) begin
      trunc_n++;
      trunc_c = cyc;
    end
    if (busy) busy_n++;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i]) qh[i]++;
    end
    drive();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    tx_full = 1'b0;
    flush_reqs();
    step();
    step();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    rst     = 1'b1;
    tx_full = 1'b0;
    clear_log();
    flush_reqs();

    // Reset state
    do_reset();
    step();
    check("rst_wen",   {31'd0, o_wen},   32'd0);
    check("rst_ready", {28'd0, o_ready}, 32'd0);
    check("rst_busy",  {31'd0, o_busy},  32'd0);
    check("rst_gid",   {30'd0, o_gid},   32'd0);
    check("rst_trunc", {31'd0, o_trunc}, 32'd0);

    // Single 3-byte packet from requester 2
    clear_log();
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b0);
    push(2, 8'h43, 1'b1);
    repeat (10) step();
    check("t1_count", nlog, 3);
    check("t1_d0", log_d[0], 8'h41);
    check("t1_d1", log_d[1], 8'h42);
    check("t1_d2", log_d[2], 8'h43);
    check("t1_gid", log_g[0], 2);
    check("t1_back2back", log_c[2] - log_c[0], 2);
    check("t1_busy_cycles", busy_n, 3);
    check("t1_busy_end", {31'd0, o_busy}, 32'd0);

    // Round robin between requesters 0 and 1
    do_reset();
    push(0, 8'h10, 1'b0);
    push(0, 8'h11, 1'b1);
    push(0, 8'h12, 1'b0);
    push(0, 8'h13, 1'b1);
    push(1, 8'h20, 1'b0);
    push(1, 8'h21, 1'b1);
    push(1, 8'h22, 1'b1);
    drive();
    repeat (20) step();
    check("t2_count", nlog, 7);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("t2_d%0d", k), log_d[k], t2_d[k]);
      check($sformatf("t2_g%0d", k), log_g[k], t2_g[k]);
    end
    check("t2_turnaround", log_c[2] - log_c[1], 2);

    // FIFO full for 5 cycles mid-packet
    do_reset();
    push(1, 8'h30, 1'b0);
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b0);
    push(1, 8'h33, 1'b1);
    drive();
    for (int k = 0; k < 10 && nlog < 1; k++) step();
    check("t3_first", nlog, 1);
    begin
      int full_wen;
      int full_rdy;
      int full_busy;
      full_wen  = 0;
      full_rdy  = 0;
      full_busy = 0;
      tx_full   = 1'b1;
      repeat (5) begin
        step();
        full_wen  += int'(o_wen);
        full_rdy  += int'(o_ready[1]);
        full_busy += int'(o_busy);
      end
      tx_full = 1'b0;
      check("t3_full_wen", full_wen, 0);
      check("t3_full_ready", full_rdy, 0);
      check("t3_full_busy", full_busy, 5);
    end
    repeat (10) step();
    check("t3_count", nlog, 4);
    check("t3_d1", log_d[1], 8'h31);
    check("t3_d2", log_d[2], 8'h32);
    check("t3_d3", log_d[3], 8'h33);
    check("t3_resume_gap", log_c[1] - log_c[0], 6);

    // Truncation at MAXLEN=4 for a 6-byte packet from requester 3
    do_reset();
    for (int k = 0; k < 6; k++) push(3, 8'(8'h50 + k), (k == 5));
    drive();
    repeat (20) step();
    check("t4_count", nlog, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t4_d%0d", k), log_d[k], 8'h50 + k);
      check($sformatf("t4_g%0d", k), log_g[k], 3);
    end
    check("t4_trunc_pulses", trunc_n, 1);
    check("t4_trunc_when", trunc_c, log_c[3] + 1);
    check("t4_relock_gap", log_c[4] - log_c[3], 2);

    // Reset mid-packet, then requester 0 wins over requester 1
    do_reset();
    for (int k = 0; k < 5; k++) push(1, 8'(8'h60 + k), (k == 4));
    drive();
    for (int k = 0; k < 10 && nlog < 2; k++) step();
    check("t5_pre", nlog, 2);
    rst = 1'b1;
    push(0, 8'h70, 1'b1);
    drive();
    step();
    check("t5_rst_wen", {31'd0, o_wen}, 32'd0);
    check("t5_rst_ready", {28'd0, o_ready}, 32'd0);
    check("t5_rst_nolog", nlog, 2);
    rst = 1'b0;
    clear_log();
    for (int k = 0; k < 10 && nlog < 1; k++) step();
    check("t5_first", nlog, 1);
    check("t5_win_gid", log_g[0], 0);
    check("t5_win_data", log_d[0], 8'h70);
    repeat (10) step();
    check("t5_count", nlog, 4);
    check("t5_d1", log_d[1], 8'h62);
    check("t5_d3", log_d[3], 8'h64);
    check("t5_g3", log_g[3], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
